peak_detect_core_p: RTL and testbench
=====================================

PEAK_DETECT_CORE_P -- requirements
Module: peak_detect_core_p

Interface
REQ-001 SHALL have parameter ROWS, default 32, meaning image row count.
REQ-002 SHALL have parameter COLS, default 32, meaning image column count.
REQ-003 SHALL have parameter DW, default 8, meaning pixel data width.
REQ-004 SHALL have parameter MAX_PEAKS, default 8, meaning peak table depth.
REQ-005 SHALL have parameter RD_LAT, default 1, meaning BRAM read latency in cycles.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port bram_rd_addr, output, clog2(ROWS*COLS) bits: raster pixel address, row*COLS+col.
REQ-009 SHALL have port bram_rd_data, input, DW bits: pixel data, valid RD_LAT cycles after its address.
REQ-010 SHALL have port detect_start, input, 1 bit: a rising edge requests a scan.
REQ-011 SHALL have port threshold, input, DW bits: minimum peak value, sampled at scan start.
REQ-012 SHALL have port conn8, input, 1 bit: 1 selects 8-neighbour mode, 0 selects 4-neighbour mode; sampled at scan start.
REQ-013 SHALL have port detect_busy, output, 1 bit: scan in progress.
REQ-014 SHALL have port detect_finish, output, 1 bit: results valid.
REQ-015 SHALL have port detect_overflow, output, 1 bit: more than MAX_PEAKS peaks were found.
REQ-016 SHALL have port detect_peak_num, output, clog2(MAX_PEAKS+1) bits: count of stored peaks.
REQ-017 SHALL have port disp_peak_idx, input, clog2(MAX_PEAKS) bits: index of the peak table entry to read.
REQ-018 SHALL have ports disp_peak_row, disp_peak_col and disp_peak_val, outputs, clog2(ROWS), clog2(COLS) and DW bits: the selected peak entry.

Function
REQ-019 SHALL run FSM states IDLE, SCAN, FLUSH and DONE.
- IDLE->SCAN on a detect_start rising edge.
- SCAN->FLUSH after the last address is issued.
- FLUSH->DONE once every pixel has been classified.
- DONE->SCAN on the next rising edge.
REQ-020 SHALL detect the rising edge with a registered copy of detect_start; the edge is detected one cycle after the input rises.
REQ-021 SHALL ignore rising edges seen in SCAN or FLUSH; deasserting detect_start mid-scan SHALL NOT abort the scan.
REQ-022 SHALL issue addresses 0..ROWS*COLS-1 in SCAN, one per cycle, increasing, with no gaps.
REQ-023 SHALL hold bram_rd_addr at 0 outside SCAN.
REQ-024 SHALL classify pixel (r,c) as a peak when its value is at least threshold and strictly greater than every in-bounds neighbour.
- Neighbours are N/S/E/W when conn8=0, plus the diagonals when conn8=1.
- Out-of-image neighbours are ignored; no padding value is used.
REQ-025 SHALL reject equal-valued plateaus, because the comparison is strict.
REQ-026 SHALL record peaks in raster order into table entries 0..MAX_PEAKS-1, each entry holding row, col and val.
REQ-027 SHALL, when the table is full, drop further peaks, set detect_overflow and saturate detect_peak_num at MAX_PEAKS.
REQ-028 SHALL, on entering SCAN, clear detect_finish, detect_overflow and detect_peak_num, and assert detect_busy.
REQ-029 SHALL assert detect_finish and deassert detect_busy on entering DONE.
- Both levels hold until the next scan starts or reset.
- Entry to DONE SHALL occur no more than ROWS*COLS+COLS+RD_LAT+4 cycles after the edge is detected.
REQ-030 SHALL drive disp_peak_* combinationally from disp_peak_idx.
- Outputs are all zero when detect_finish=0 or disp_peak_idx>=detect_peak_num.
REQ-031 SHALL produce results independent of threshold and conn8 changes made after the scan starts.

Reset
REQ-032 SHALL, on asserting rstn=0, asynchronously force:
- FSM to IDLE;
- bram_rd_addr, detect_peak_num and disp_peak_* to 0;
- detect_busy, detect_finish and detect_overflow to 0.
REQ-033 SHALL discard any partial scan on reset and require a new rising edge of detect_start after rstn releases.

Structure
REQ-034 SHALL place the FSM state enum and the width helpers (address, row, col and count widths) in the shared package peak_detect_pkg.
REQ-035 SHALL implement the two-row line buffer plus 3x3 window shift registers as the single sub-module peak_window_buf, parametrised by COLS and DW.

Verification
REQ-036 SHALL cover: all-zero 32x32 image, threshold 0 -> detect_peak_num=0, detect_overflow=0, finish within the REQ-029 bound.
REQ-037 SHALL cover: single pixel 200 at (10,15) on a zero background -> detect_peak_num=1; idx 0 gives row 10, col 15, val 200; idx 1 gives all zeros.
REQ-038 SHALL cover: (5,5)=100 and (5,6)=100 plateau -> 0 peaks; (0,0)=50 corner -> 0 peaks with threshold 60, 1 peak with threshold 50.
REQ-039 SHALL cover: (8,8)=90 and (9,9)=80 -> conn8=0 gives 2 peaks; conn8=1 gives 1 peak at (8,8).
REQ-040 SHALL cover: 9 isolated peaks of 150, MAX_PEAKS=8 -> detect_peak_num=8, detect_overflow=1, entries in raster order.
REQ-041 SHALL cover: rstn pulsed low mid-SCAN, then a new start on an unchanged image -> all outputs zero during reset; the rerun matches the uninterrupted result.

Source files
------------

// File: rtl/peak_detect_pkg.sv
// Shared types and width helpers for the peak detector.
package peak_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } pd_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int addr_w(input int rows, input int cols);
    return clog2_min1(rows * cols);
  endfunction

  function automatic int row_w(input int rows);
    return clog2_min1(rows);
  endfunction

  function automatic int col_w(input int cols);
    return clog2_min1(cols);
  endfunction

  function automatic int cnt_w(input int max_peaks);
    return clog2_min1(max_peaks + 1);
  endfunction

  function automatic int idx_w(input int max_peaks);
    return clog2_min1(max_peaks);
  endfunction

endpackage

// File: rtl/peak_detect_core_p_window.sv
// Two-row line buffer feeding a 3x3 sliding window; win[row][col], row 0 oldest, col 2 newest.
module peak_window_buf
  import peak_detect_pkg::*;
#(
  parameter int COLS = 32,
  parameter int DW   = 8
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      shift_en,
  input  logic [col_w(COLS)-1:0]    col,
  input  logic [DW-1:0]             pix,
  output logic [2:0][2:0][DW-1:0]   win
);

  logic [DW-1:0]      lb_top [COLS];
  logic [DW-1:0]      lb_mid [COLS];
  logic [2:0][DW-1:0] new_col;

  always_comb begin
    new_col[0] = lb_top[col];
    new_col[1] = lb_mid[col];
    new_col[2] = pix;
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= pix;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
        win[i][2] <= new_col[i];
      end
    end
  end

endmodule

// File: rtl/peak_detect_core_p.sv
// Raster-scan local-maximum detector over a BRAM image with a small peak table.
//   state | meaning
//   IDLE  | waiting for first detect_start rising edge
//   SCAN  | issuing pixel addresses 0..ROWS*COLS-1
//   FLUSH | draining read latency and pushing virtual steps to finish the last row
//   DONE  | results valid, waiting for the next rising edge
module peak_detect_core_p
  import peak_detect_pkg::*;
#(
  parameter int ROWS      = 32,
  parameter int COLS      = 32,
  parameter int DW        = 8,
  parameter int MAX_PEAKS = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  output logic [addr_w(ROWS, COLS)-1:0]   bram_rd_addr,
  input  logic [DW-1:0]                   bram_rd_data,
  input  logic                            detect_start,
  input  logic [DW-1:0]                   threshold,
  input  logic                            conn8,
  output logic                            detect_busy,
  output logic                            detect_finish,
  output logic                            detect_overflow,
  output logic [cnt_w(MAX_PEAKS)-1:0]     detect_peak_num,
  input  logic [idx_w(MAX_PEAKS)-1:0]     disp_peak_idx,
  output logic [row_w(ROWS)-1:0]          disp_peak_row,
  output logic [col_w(COLS)-1:0]          disp_peak_col,
  output logic [DW-1:0]                   disp_peak_val
);

  localparam int AW  = addr_w(ROWS, COLS);
  localparam int RW  = row_w(ROWS);
  localparam int CW  = col_w(COLS);
  localparam int NW  = cnt_w(MAX_PEAKS);
  localparam int IW  = idx_w(MAX_PEAKS);
  localparam int SRW = clog2_min1(ROWS + 2);
  localparam int FW  = clog2_min1(COLS + 2);
  localparam logic [AW-1:0] LAST_ADDR = AW'(ROWS * COLS - 1);

  pd_state_e         state;
  logic              start_q;
  logic [DW-1:0]     thr_q;
  logic              conn8_q;
  logic [RD_LAT-1:0] vld_q;
  logic [FW-1:0]     flush_cnt;
  logic [SRW-1:0]    step_r;
  logic [CW-1:0]     step_c;
  logic              eval_v;
  logic [RW-1:0]     ctr_row;
  logic [CW-1:0]     ctr_col;

  logic [RW-1:0]     tbl_row [MAX_PEAKS];
  logic [CW-1:0]     tbl_col [MAX_PEAKS];
  logic [DW-1:0]     tbl_val [MAX_PEAKS];

  logic                    start_edge, scan_go, data_v, virt_en, step_en;
  logic [DW-1:0]           pix, ctr;
  logic                    has_n, has_s, has_w, has_e, is_peak;
  logic [2:0][2:0][DW-1:0] win;

  assign start_edge = detect_start & ~start_q;
  assign scan_go    = start_edge && (state == ST_IDLE || state == ST_DONE);
  assign data_v     = vld_q[RD_LAT-1];
  // Virtual steps only start once every real pixel has left the read pipeline.
  assign virt_en    = (state == ST_FLUSH) && !(|vld_q) && (flush_cnt != '0);
  assign step_en    = data_v | virt_en;
  assign pix        = data_v ? bram_rd_data : '0;

  peak_window_buf #(.COLS(COLS), .DW(DW)) u_win (
    .clk      (clk),
    .rstn     (rstn),
    .shift_en (step_en),
    .col      (step_c),
    .pix      (pix),
    .win      (win)
  );

  always_comb begin
    ctr     = win[1][1];
    has_n   = (ctr_row != '0);
    has_s   = (ctr_row != RW'(ROWS - 1));
    has_w   = (ctr_col != '0);
    has_e   = (ctr_col != CW'(COLS - 1));
    is_peak = (ctr >= thr_q);
    if (has_n && ctr <= win[0][1]) is_peak = 1'b0;
    if (has_s && ctr <= win[2][1]) is_peak = 1'b0;
    if (has_w && ctr <= win[1][0]) is_peak = 1'b0;
    if (has_e && ctr <= win[1][2]) is_peak = 1'b0;
    if (conn8_q) begin
      if (has_n && has_w && ctr <= win[0][0]) is_peak = 1'b0;
      if (has_n && has_e && ctr <= win[0][2]) is_peak = 1'b0;
      if (has_s && has_w && ctr <= win[2][0]) is_peak = 1'b0;
      if (has_s && has_e && ctr <= win[2][2]) is_peak = 1'b0;
    end
  end

  // Step (r,c) centres on (r-1,c-1); a column-0 step finishes (r-2,COLS-1).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q   <= '0;
      step_r  <= '0;
      step_c  <= '0;
      eval_v  <= 1'b0;
      ctr_row <= '0;
      ctr_col <= '0;
    end else begin
      vld_q <= RD_LAT'({vld_q, (state == ST_SCAN)});
      if (scan_go) begin
        step_r <= '0;
        step_c <= '0;
        eval_v <= 1'b0;
      end else begin
        eval_v <= step_en && ((step_c != '0) ? (step_r >= SRW'(1)) : (step_r >= SRW'(2)));
        if (step_en) begin
          ctr_row <= (step_c != '0) ? RW'(step_r - SRW'(1)) : RW'(step_r - SRW'(2));
          ctr_col <= (step_c != '0) ? (step_c - CW'(1)) : CW'(COLS - 1);
          if (step_c == CW'(COLS - 1)) begin
            step_c <= '0;
            step_r <= step_r + SRW'(1);
          end else begin
            step_c <= step_c + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= ST_IDLE;
      start_q         <= 1'b0;
      thr_q           <= '0;
      conn8_q         <= 1'b0;
      flush_cnt       <= '0;
      bram_rd_addr    <= '0;
      detect_busy     <= 1'b0;
      detect_finish   <= 1'b0;
      detect_overflow <= 1'b0;
      detect_peak_num <= '0;
    end else begin
      start_q <= detect_start;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            state           <= ST_SCAN;
            bram_rd_addr    <= '0;
            thr_q           <= threshold;
            conn8_q         <= conn8;
            detect_busy     <= 1'b1;
            detect_finish   <= 1'b0;
            detect_overflow <= 1'b0;
            detect_peak_num <= '0;
          end
        end
        ST_SCAN: begin
          if (bram_rd_addr == LAST_ADDR) begin
            state        <= ST_FLUSH;
            bram_rd_addr <= '0;
            flush_cnt    <= FW'(COLS + 1);
          end else begin
            bram_rd_addr <= bram_rd_addr + AW'(1);
          end
        end
        ST_FLUSH: begin
          if (virt_en) flush_cnt <= flush_cnt - FW'(1);
          if (flush_cnt == '0 && eval_v) begin
            state         <= ST_DONE;
            detect_busy   <= 1'b0;
            detect_finish <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (eval_v && is_peak) begin
        if (detect_peak_num < NW'(MAX_PEAKS)) detect_peak_num <= detect_peak_num + NW'(1);
        else detect_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (eval_v && is_peak && detect_peak_num < NW'(MAX_PEAKS)) begin
      tbl_row[IW'(detect_peak_num)] <= ctr_row;
      tbl_col[IW'(detect_peak_num)] <= ctr_col;
      tbl_val[IW'(detect_peak_num)] <= ctr;
    end
  end

  always_comb begin
    disp_peak_row = '0;
    disp_peak_col = '0;
    disp_peak_val = '0;
    if (detect_finish && (NW'(disp_peak_idx) < detect_peak_num)) begin
      disp_peak_row = tbl_row[disp_peak_idx];
      disp_peak_col = tbl_col[disp_peak_idx];
      disp_peak_val = tbl_val[disp_peak_idx];
    end
  end

endmodule

// File: tb/tb_peak_detect_core_p.sv
// Directed bench for peak_detect_core_p on a 32x32 image with a one-cycle BRAM model.
module tb_peak_detect_core_p;

  localparam int ROWS   = 32;
  localparam int COLS   = 32;
  localparam int RD_LAT = 1;
  localparam int NPIX   = ROWS * COLS;
  localparam int BOUND  = NPIX + COLS + RD_LAT + 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [9:0] bram_rd_addr;
  logic [7:0] bram_rd_data;
  logic       detect_start;
  logic [7:0] threshold;
  logic       conn8;
  logic       detect_busy, detect_finish, detect_overflow;
  logic [3:0] detect_peak_num;
  logic [2:0] disp_peak_idx;
  logic [4:0] disp_peak_row, disp_peak_col;
  logic [7:0] disp_peak_val;

  logic [7:0] img [NPIX];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) bram_rd_data <= img[bram_rd_addr];

  peak_detect_core_p dut (
    .clk             (clk),
    .rstn            (rstn),
    .bram_rd_addr    (bram_rd_addr),
    .bram_rd_data    (bram_rd_data),
    .detect_start    (detect_start),
    .threshold       (threshold),
    .conn8           (conn8),
    .detect_busy     (detect_busy),
    .detect_finish   (detect_finish),
    .detect_overflow (detect_overflow),
    .detect_peak_num (detect_peak_num),
    .disp_peak_idx   (disp_peak_idx),
    .disp_peak_row   (disp_peak_row),
    .disp_peak_col   (disp_peak_col),
    .disp_peak_val   (disp_peak_val)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_peak(input string tag, input int idx, input int er, input int ec, input int ev);
    disp_peak_idx = 3'(idx);
    #1;
    check({tag, "_row"}, 32'(disp_peak_row), 32'(er));
    check({tag, "_col"}, 32'(disp_peak_col), 32'(ec));
    check({tag, "_val"}, 32'(disp_peak_val), 32'(ev));
  endtask

  task automatic clear_img();
    for (int i = 0; i < NPIX; i++) img[i] = 8'd0;
  endtask

  task automatic set_px(input int r, input int c, input int v);
    img[r * COLS + c] = 8'(v);
  endtask

  // mid_pulse re-raises detect_start during the scan; mid_change alters threshold/conn8 after start.
  task automatic run_scan(input string tag, input logic [7:0] thr, input logic c8,
                          input bit mid_pulse, input bit mid_change);
    int cyc;
    bit addr_ok;
    int exp_addr;
    @(negedge clk);
    threshold    = thr;
    conn8        = c8;
    detect_start = 1'b1;
    @(posedge clk);
    #1;
    detect_start = 1'b0;
    check({tag, "_busy_on"}, 32'(detect_busy), 32'd1);
    check({tag, "_fin_clr"}, 32'(detect_finish), 32'd0);
    cyc     = 0;
    addr_ok = 1'b1;
    while (!detect_finish && cyc < 3000) begin
      if (mid_change && cyc == 5) begin
        threshold = 8'hFF;
        conn8     = ~c8;
      end
      if (mid_pulse && cyc == 100) detect_start = 1'b1;
      if (mid_pulse && cyc == 102) detect_start = 1'b0;
      exp_addr = (cyc < NPIX) ? cyc : 0;
      if (int'(bram_rd_addr) != exp_addr) addr_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_in_bound"}, 32'(cyc <= BOUND), 32'd1);
    check({tag, "_addr_seq"}, 32'(addr_ok), 32'd1);
    check({tag, "_busy_off"}, 32'(detect_busy), 32'd0);
  endtask

  initial begin
    rstn          = 1'b0;
    detect_start  = 1'b0;
    threshold     = 8'd0;
    conn8         = 1'b0;
    disp_peak_idx = 3'd0;
    clear_img();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(detect_busy), 32'd0);
    check("rst_fin",  32'(detect_finish), 32'd0);
    check("rst_ovf",  32'(detect_overflow), 32'd0);
    check("rst_num",  32'(detect_peak_num), 32'd0);
    check("rst_addr", 32'(bram_rd_addr), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // all-zero image, threshold 0
    run_scan("zero", 8'd0, 1'b0, 1'b0, 1'b0);
    check("zero_fin", 32'(detect_finish), 32'd1);
    check("zero_num", 32'(detect_peak_num), 32'd0);
    check("zero_ovf", 32'(detect_overflow), 32'd0);
    check_peak("zero_p0", 0, 0, 0, 0);

    // single pixel; threshold/conn8 changed after start must not matter
    clear_img();
    set_px(10, 15, 200);
    run_scan("single", 8'd100, 1'b1, 1'b0, 1'b1);
    check("single_num", 32'(detect_peak_num), 32'd1);
    check_peak("single_p0", 0, 10, 15, 200);
    check_peak("single_p1", 1, 0, 0, 0);

    // equal plateau is rejected
    clear_img();
    set_px(5, 5, 100);
    set_px(5, 6, 100);
    run_scan("plateau", 8'd50, 1'b0, 1'b0, 1'b0);
    check("plateau_num", 32'(detect_peak_num), 32'd0);

    // corner pixel against threshold
    clear_img();
    set_px(0, 0, 50);
    run_scan("corner60", 8'd60, 1'b0, 1'b0, 1'b0);
    check("corner60_num", 32'(detect_peak_num), 32'd0);
    run_scan("corner50", 8'd50, 1'b0, 1'b0, 1'b0);
    check("corner50_num", 32'(detect_peak_num), 32'd1);
    check_peak("corner50_p0", 0, 0, 0, 50);

    // very last pixel of the raster
    clear_img();
    set_px(31, 31, 77);
    run_scan("last", 8'd1, 1'b1, 1'b0, 1'b0);
    check("last_num", 32'(detect_peak_num), 32'd1);
    check_peak("last_p0", 0, 31, 31, 77);

    // diagonal neighbours: 4- vs 8-connectivity; second run also gets a mid-scan start pulse
    clear_img();
    set_px(8, 8, 90);
    set_px(9, 9, 80);
    run_scan("diag4", 8'd10, 1'b0, 1'b0, 1'b1);
    check("diag4_num", 32'(detect_peak_num), 32'd2);
    check_peak("diag4_p0", 0, 8, 8, 90);
    check_peak("diag4_p1", 1, 9, 9, 80);
    run_scan("diag8", 8'd10, 1'b1, 1'b1, 1'b0);
    check("diag8_num", 32'(detect_peak_num), 32'd1);
    check_peak("diag8_p0", 0, 8, 8, 90);
    check_peak("diag8_p1", 1, 0, 0, 0);

    // nine peaks overflow an eight-entry table
    clear_img();
    set_px(2, 2, 150);
    set_px(2, 10, 150);
    set_px(2, 20, 150);
    set_px(10, 3, 150);
    set_px(10, 30, 150);
    set_px(20, 0, 150);
    set_px(20, 15, 150);
    set_px(31, 5, 150);
    set_px(31, 31, 150);
    run_scan("ovf", 8'd100, 1'b1, 1'b0, 1'b0);
    check("ovf_num", 32'(detect_peak_num), 32'd8);
    check("ovf_flag", 32'(detect_overflow), 32'd1);
    check_peak("ovf_p0", 0, 2, 2, 150);
    check_peak("ovf_p4", 4, 10, 30, 150);
    check_peak("ovf_p5", 5, 20, 0, 150);
    check_peak("ovf_p7", 7, 31, 5, 150);

    // reset mid-scan, then rerun on the diagonal image with 4-connectivity
    clear_img();
    set_px(8, 8, 90);
    set_px(9, 9, 80);
    @(negedge clk);
    threshold     = 8'd10;
    conn8         = 1'b0;
    detect_start  = 1'b1;
    disp_peak_idx = 3'd0;
    @(negedge clk);
    detect_start = 1'b0;
    repeat (300) @(negedge clk);
    check("mid_busy", 32'(detect_busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("rstmid_busy", 32'(detect_busy), 32'd0);
    check("rstmid_fin",  32'(detect_finish), 32'd0);
    check("rstmid_ovf",  32'(detect_overflow), 32'd0);
    check("rstmid_num",  32'(detect_peak_num), 32'd0);
    check("rstmid_addr", 32'(bram_rd_addr), 32'd0);
    check("rstmid_row",  32'(disp_peak_row), 32'd0);
    check("rstmid_col",  32'(disp_peak_col), 32'd0);
    check("rstmid_val",  32'(disp_peak_val), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle_busy", 32'(detect_busy), 32'd0);
    check("post_rst_idle_fin",  32'(detect_finish), 32'd0);
    run_scan("rerun", 8'd10, 1'b0, 1'b0, 1'b0);
    check("rerun_num", 32'(detect_peak_num), 32'd2);
    check("rerun_ovf", 32'(detect_overflow), 32'd0);
    check_peak("rerun_p0", 0, 8, 8, 90);
    check_peak("rerun_p1", 1, 9, 9, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
